// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared types and constants for the UART transmit output peripheral.
//   uart_state_t  : transmitter FSM states
//   *_LEVEL       : serial line levels for idle, start and stop bits
//   DATA_BITS     : payload bits per frame
//   even_parity() : parity bit sent in the optional PARITY slot
// -----------------------------------------------------------------------------
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } uart_state_t;

    localparam logic        IDLE_LEVEL  = 1'b1;
    localparam logic        START_LEVEL = 1'b0;
    localparam logic        STOP_LEVEL  = 1'b1;
    localparam int unsigned DATA_BITS   = 8;

    // Even parity: the XOR of the data bits, so data plus parity has an even count of ones.
    function automatic logic even_parity(input logic [DATA_BITS-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/uart_tx_out_fifo.sv
// -----------------------------------------------------------------------------
// sync_fifo
// Single-clock FIFO with wrap-bit pointers.
// Parameters: WIDTH (entry width), DEPTH (entries; power of two, >= 2)
// Ports:
//   clk   in   rising-edge clock
//   rst_n in   asynchronous active-low reset (empties the FIFO)
//   push  in   write din at the tail; ignored while full
//   pop   in   discard the head entry; ignored while empty
//   din   in   write data
//   dout  out  head entry (valid while !empty)
//   full  out  DEPTH entries held
//   empty out  no entries held
// -----------------------------------------------------------------------------
module sync_fifo #(
    parameter int unsigned WIDTH = 8,
    parameter int unsigned DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] dout,
    output logic             full,
    output logic             empty
);

    localparam int unsigned AW = $clog2(DEPTH);

    logic [AW:0]      wr_ptr_r;
    logic [AW:0]      rd_ptr_r;
    logic [WIDTH-1:0] mem_r [DEPTH];
    logic             push_ok_s;
    logic             pop_ok_s;

    // Pointers that match except for the wrap bit mean the writer is a full lap ahead.
    assign full  = (wr_ptr_r[AW] != rd_ptr_r[AW]) && (wr_ptr_r[AW-1:0] == rd_ptr_r[AW-1:0]);
    assign empty = (wr_ptr_r == rd_ptr_r);
    assign dout  = mem_r[rd_ptr_r[AW-1:0]];

    // Qualify requests against the registered flags so an overflowing write never clobbers data.
    always_comb begin
        push_ok_s = push && !full;
        pop_ok_s  = pop && !empty;
    end

    // Pointer and storage update.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= '0;
            rd_ptr_r <= '0;
            for (int unsigned i = 0; i < DEPTH; i++) begin
                mem_r[i] <= '0;
            end
        end else begin
            if (push_ok_s) begin
                mem_r[wr_ptr_r[AW-1:0]] <= din;
                wr_ptr_r                <= wr_ptr_r + {{AW{1'b0}}, 1'b1};
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + {{AW{1'b0}}, 1'b1};
            end
        end
    end

endmodule

// File: rtl/uart_tx_out.sv
// -----------------------------------------------------------------------------
// uart_tx_out
// Serial output peripheral fed by the CPU OUT instruction. Bytes written to
// port TX_PORT are buffered in a FIFO and sent as UART frames, LSB first:
// start, 8 data bits, optional even parity, stop.
// Build option: define UART_TX_PARITY_EN to insert an even-parity bit
// (11-bit frames); without it frames are 8N1.
// Parameters: CLKS_PER_BIT (>= 2), FIFO_DEPTH (power of two, >= 2), TX_PORT
// Ports:
//   clk      in   system clock, rising edge
//   reset    in   asynchronous active-low reset
//   we_out   in   CPU output-write strobe
//   port_sel in   output port address
//   wdata    in   byte to send
//   tx       out  serial line, idle high, registered
//   busy     out  frame in progress or bytes waiting
//   full     out  FIFO full
//   ovf      out  sticky: a write was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module uart_tx_out import uart_pkg::*; #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter int unsigned FIFO_DEPTH   = 4,
    parameter logic [1:0]  TX_PORT      = 2'd3
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we_out,
    input  logic [1:0] port_sel,
    input  logic [7:0] wdata,
    output logic       tx,
    output logic       busy,
    output logic       full,
    output logic       ovf
);

    localparam int unsigned        CNT_W   = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]   CNT_MAX = CNT_W'(CLKS_PER_BIT - 1);

    uart_state_t          state_r;
    logic [CNT_W-1:0]     baud_cnt_r;
    logic [2:0]           bit_idx_r;
    logic [DATA_BITS-1:0] shreg_r;
    logic                 tx_r;
    logic                 ovf_r;
`ifdef UART_TX_PARITY_EN
    logic                 par_r;
`endif

    logic                 push_req_s;
    logic                 pop_s;
    logic                 baud_tc_s;
    logic [DATA_BITS-1:0] fifo_dout_s;
    logic                 full_s;
    logic                 empty_s;

    sync_fifo #(
        .WIDTH (DATA_BITS),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst_n (reset),
        .push  (push_req_s),
        .pop   (pop_s),
        .din   (wdata),
        .dout  (fifo_dout_s),
        .full  (full_s),
        .empty (empty_s)
    );

    assign tx   = tx_r;
    assign full = full_s;
    assign ovf  = ovf_r;
    assign busy = (state_r != IDLE) || !empty_s;

    // Port decode, terminal count and head-pop request (from IDLE, or at the end of STOP
    // so that queued bytes follow with no idle gap).
    always_comb begin
        push_req_s = we_out && (port_sel == TX_PORT);
        baud_tc_s  = (baud_cnt_r == CNT_MAX);
        if ((state_r == IDLE) && !empty_s) begin
            pop_s = 1'b1;
        end else if ((state_r == STOP) && baud_tc_s && !empty_s) begin
            pop_s = 1'b1;
        end else begin
            pop_s = 1'b0;
        end
    end

    // Sticky overflow: uses the registered full flag, before any same-cycle pop.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            ovf_r <= 1'b0;
        end else if (push_req_s && full_s) begin
            ovf_r <= 1'b1;
        end
    end

    // Baud counter: parked at zero in IDLE, otherwise wraps every CLKS_PER_BIT cycles.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            baud_cnt_r <= '0;
        end else if ((state_r == IDLE) || baud_tc_s) begin
            baud_cnt_r <= '0;
        end else begin
            baud_cnt_r <= baud_cnt_r + {{(CNT_W-1){1'b0}}, 1'b1};
        end
    end

    // Transmit FSM; tx is updated only when a state or bit slot begins.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            bit_idx_r <= 3'd0;
            shreg_r   <= '0;
            tx_r      <= IDLE_LEVEL;
`ifdef UART_TX_PARITY_EN
            par_r     <= 1'b0;
`endif
        end else begin
            case (state_r)
                IDLE: begin
                    bit_idx_r <= 3'd0;
                    if (pop_s) begin
                        shreg_r <= fifo_dout_s;
`ifdef UART_TX_PARITY_EN
                        par_r   <= even_parity(fifo_dout_s);
`endif
                        tx_r    <= START_LEVEL;
                        state_r <= START;
                    end else begin
                        tx_r    <= IDLE_LEVEL;
                    end
                end
                START: begin
                    if (baud_tc_s) begin
                        // Present bit 0 and pre-shift so shreg_r[0] is always the next bit.
                        tx_r      <= shreg_r[0];
                        shreg_r   <= {1'b0, shreg_r[DATA_BITS-1:1]};
                        bit_idx_r <= 3'd0;
                        state_r   <= DATA;
                    end
                end
                DATA: begin
                    if (baud_tc_s) begin
                        if (bit_idx_r == 3'd7) begin
`ifdef UART_TX_PARITY_EN
                            tx_r    <= par_r;
                            state_r <= PARITY;
`else
                            tx_r    <= STOP_LEVEL;
                            state_r <= STOP;
`endif
                        end else begin
                            tx_r      <= shreg_r[0];
                            shreg_r   <= {1'b0, shreg_r[DATA_BITS-1:1]};
                            bit_idx_r <= bit_idx_r + 3'd1;
                        end
                    end
                end
`ifdef UART_TX_PARITY_EN
                PARITY: begin
                    if (baud_tc_s) begin
                        tx_r    <= STOP_LEVEL;
                        state_r <= STOP;
                    end
                end
`endif
                STOP: begin
                    if (baud_tc_s) begin
                        bit_idx_r <= 3'd0;
                        if (pop_s) begin
                            shreg_r <= fifo_dout_s;
`ifdef UART_TX_PARITY_EN
                            par_r   <= even_parity(fifo_dout_s);
`endif
                            tx_r    <= START_LEVEL;
                            state_r <= START;
                        end else begin
                            tx_r    <= IDLE_LEVEL;
                            state_r <= IDLE;
                        end
                    end
                end
                default: begin
                    // Unreachable encodings recover to a quiet line.
                    tx_r    <= IDLE_LEVEL;
                    state_r <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_out.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_out
// Bench for uart_tx_out with CLKS_PER_BIT=4, FIFO_DEPTH=4, TX_PORT=3.
// Accepted bytes go into a scoreboard queue; a line monitor pops one per frame
// and checks every cycle of the frame against the expected bit pattern.
// Define UART_TX_PARITY_EN for both RTL and bench to exercise parity frames.
// -----------------------------------------------------------------------------
module tb_uart_tx_out;

    localparam int CPB = 4;
`ifdef UART_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME_CYC = NBITS * CPB;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       we_out = 1'b0;
    logic [1:0] port_sel = 2'd0;
    logic [7:0] wdata = 8'd0;
    logic       tx;
    logic       busy;
    logic       full;
    logic       ovf;

    int n_checks = 0;
    int n_fail   = 0;

    logic [7:0] sb [$];

    typedef struct {
        logic [1:0] port;
        logic [7:0] data;
        logic       exp_enq;
    } vec_t;
    vec_t vecs [6];

    uart_tx_out #(
        .CLKS_PER_BIT (CPB),
        .FIFO_DEPTH   (4),
        .TX_PORT      (2'd3)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .we_out   (we_out),
        .port_sel (port_sel),
        .wdata    (wdata),
        .tx       (tx),
        .busy     (busy),
        .full     (full),
        .ovf      (ovf)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // Expected line levels for one frame, index = bit slot.
    function automatic logic [10:0] build_frame(input logic [7:0] d);
        logic [10:0] f;
        f      = 11'h7FF;
        f[0]   = 1'b0;
        f[8:1] = d;
`ifdef UART_TX_PARITY_EN
        f[9]   = ^d;
`endif
        return f;
    endfunction

    // Line monitor: one frame at a time, every cycle compared against the expected slot.
    bit          mon_active = 1'b0;
    int          mon_idx;
    int          mon_err;
    logic [7:0]  mon_exp;
    logic [7:0]  mon_got;
    logic [10:0] mon_frame;

    always @(negedge clk) begin
        if (!reset) begin
            mon_active = 1'b0;
        end else begin
            if (!mon_active && tx === 1'b0) begin
                mon_active = 1'b1;
                mon_idx    = 0;
                mon_err    = 0;
                mon_got    = 8'h00;
                check("frame_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) mon_exp = sb.pop_front();
                else mon_exp = 8'h00;
                mon_frame = build_frame(mon_exp);
            end
            if (mon_active) begin
                if (tx !== mon_frame[mon_idx / CPB]) mon_err++;
                if ((mon_idx % CPB) == 2 && (mon_idx / CPB) >= 1 && (mon_idx / CPB) <= 8)
                    mon_got[(mon_idx / CPB) - 1] = tx;
                mon_idx++;
                if (mon_idx == FRAME_CYC) begin
                    check("frame_data", 32'(mon_got), 32'(mon_exp));
                    check("frame_cycle_errors", 32'(mon_err), 32'd0);
                    mon_active = 1'b0;
                end
            end
        end
    end

    // Drive one OUT write; called at a negedge, returns at the following negedge.
    task automatic write(input logic [1:0] p, input logic [7:0] d, input logic exp_enq);
        port_sel = p;
        wdata    = d;
        we_out   = 1'b1;
        if (exp_enq) sb.push_back(d);
        @(negedge clk);
        we_out   = 1'b0;
    endtask

    task automatic wait_idle(input int budget, input string name);
        int n = 0;
        while (busy === 1'b1 && n < budget) begin
            @(negedge clk);
            n++;
        end
        check(name, 32'(busy), 32'd0);
    endtask

    // Waits for the start bit, then counts cycles until busy drops.
    task automatic measure(input int exp_cycles, input string name);
        int n = 0;
        while (tx !== 1'b0 && n < 50) begin
            @(negedge clk);
            n++;
        end
        check({name, "_start_seen"}, 32'(tx), 32'd0);
        n = 0;
        while (busy === 1'b1 && n < 2000) begin
            n++;
            @(negedge clk);
        end
        check({name, "_busy_cycles"}, 32'(n), 32'(exp_cycles));
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        vecs[0] = '{2'd0, 8'h5A, 1'b0};
        vecs[1] = '{2'd1, 8'h5A, 1'b0};
        vecs[2] = '{2'd2, 8'h5A, 1'b0};
        vecs[3] = '{2'd3, 8'h3C, 1'b1};
        vecs[4] = '{2'd2, 8'hFF, 1'b0};
        vecs[5] = '{2'd3, 8'h96, 1'b1};

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_tx", 32'(tx), 32'd1);
        check("rst_busy", 32'(busy), 32'd0);
        check("rst_full", 32'(full), 32'd0);
        check("rst_ovf", 32'(ovf), 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clk);

        // Single byte: latency and frame length
        write(2'd3, 8'hA5, 1'b1);
        check("t1_busy_after_write", 32'(busy), 32'd1);
        check("t1_tx_high_same_cycle", 32'(tx), 32'd1);
        @(negedge clk);
        check("t1_tx_low_next_cycle", 32'(tx), 32'd0);
        measure(FRAME_CYC, "t1");

        // Table: non-TX ports must be ignored, TX port enqueues
        for (int i = 0; i < 6; i++) begin
            write(vecs[i].port, vecs[i].data, vecs[i].exp_enq);
            check("tbl_busy", 32'(busy), 32'(vecs[i].exp_enq));
            check("tbl_tx_high", 32'(tx), 32'd1);
            check("tbl_full", 32'(full), 32'd0);
            if (vecs[i].exp_enq) begin
                measure(FRAME_CYC, "tbl");
            end else begin
                repeat (8) @(negedge clk);
                check("tbl_ignored_busy", 32'(busy), 32'd0);
                check("tbl_ignored_tx", 32'(tx), 32'd1);
            end
        end
        repeat (3) @(negedge clk);

        // Back-to-back frames
        write(2'd3, 8'h01, 1'b1);
        write(2'd3, 8'h02, 1'b1);
        measure(2 * FRAME_CYC, "t3");
        check("t3_sb_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        // Overflow: six writes, sixth dropped
        for (int i = 0; i < 6; i++) begin
            write(2'd3, 8'h10 + 8'(i), (i < 5));
        end
        check("t4_full", 32'(full), 32'd1);
        check("t4_ovf", 32'(ovf), 32'd1);
        wait_idle(6 * FRAME_CYC, "t4_drain_timeout");
        check("t4_full_after_drain", 32'(full), 32'd0);
        check("t4_ovf_sticky", 32'(ovf), 32'd1);
        check("t4_sb_drained", 32'(sb.size()), 32'd0);
        repeat (3) @(negedge clk);

        // Mid-frame reset during data bit 3
        write(2'd3, 8'hC3, 1'b1);
        @(negedge clk);
        check("t5_tx_start", 32'(tx), 32'd0);
        repeat (17) @(negedge clk);
        #1 reset = 1'b0;
        #1;
        check("t5_tx_reset", 32'(tx), 32'd1);
        check("t5_busy_reset", 32'(busy), 32'd0);
        check("t5_full_reset", 32'(full), 32'd0);
        check("t5_ovf_reset", 32'(ovf), 32'd0);
        repeat (2) @(negedge clk);
        reset = 1'b1;
        check("t5_sb_empty", 32'(sb.size()), 32'd0);
        @(negedge clk);
        write(2'd3, 8'hFF, 1'b1);
        measure(FRAME_CYC, "t5");

`ifdef UART_TX_PARITY_EN
        // Parity slot level
        repeat (3) @(negedge clk);
        write(2'd3, 8'h07, 1'b1);
        @(negedge clk);
        repeat (38) @(negedge clk);
        check("t6_parity_07", 32'(tx), 32'd1);
        wait_idle(FRAME_CYC, "t6_idle_07");
        repeat (3) @(negedge clk);
        write(2'd3, 8'h03, 1'b1);
        @(negedge clk);
        repeat (38) @(negedge clk);
        check("t6_parity_03", 32'(tx), 32'd0);
        wait_idle(FRAME_CYC, "t6_idle_03");
        write(2'd3, 8'h07, 1'b1);
        measure(44, "t6");
`endif

        repeat (5) @(negedge clk);
        check("end_sb_empty", 32'(sb.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
